// File: rtl/prog_loader_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader_ctrl_if
// Brief    : Load stream, byte-write memory port and core run-control bundle.
// Revision : 1.0
// ============================================================================
interface prog_loader_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
);
    logic              ld_valid;
    logic              ld_ready;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;
    logic              start;
    logic              clear;
    logic [ADDR_W-1:0] core_pc;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              core_rst;
    logic              done;
    logic              timed_out;
    logic              ovf;
    logic [CNT_W-1:0]  cycle_count;

    modport master (
        output ld_valid, ld_data, ld_last, start, clear, core_pc,
        input  ld_ready, mem_we, mem_addr, mem_wdata, core_rst,
        input  done, timed_out, ovf, cycle_count
    );

    modport slave (
        input  ld_valid, ld_data, ld_last, start, clear, core_pc,
        output ld_ready, mem_we, mem_addr, mem_wdata, core_rst,
        output done, timed_out, ovf, cycle_count
    );
endinterface
`default_nettype wire

// File: rtl/prog_loader_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader_ctrl
// Brief    : Streams program words big-endian into byte memory, then runs the
//            core until it jumps to itself or the cycle budget runs out.
// Revision : 1.0
// ============================================================================
module prog_loader_ctrl #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int MEM_BYTES  = 1024,
    parameter int BASE_ADDR  = 0,
    parameter int CNT_W      = 16,
    parameter int MAX_CYCLES = 100
) (
    input  logic              clk,
    input  logic              reset,
    prog_loader_ctrl_if.slave bus
);
    localparam int                c_nb        = DATA_W / 8;
    localparam int                c_bc_w      = $clog2(c_nb + 1);
    localparam logic [1:0]        c_st_load   = 2'd0;
    localparam logic [1:0]        c_st_arm    = 2'd1;
    localparam logic [1:0]        c_st_run    = 2'd2;
    localparam logic [1:0]        c_st_done   = 2'd3;
    localparam logic [c_bc_w-1:0] c_bc_one    = c_bc_w'(1);
    localparam logic [c_bc_w-1:0] c_bc_nb     = c_bc_w'(c_nb);
    localparam logic [ADDR_W:0]   c_mem_bytes = (ADDR_W+1)'(MEM_BYTES);
    localparam logic [ADDR_W:0]   c_last_off  = (ADDR_W+1)'(c_nb - 1);
    localparam logic [ADDR_W-1:0] c_base      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] c_nb_addr   = ADDR_W'(c_nb);
    localparam logic [ADDR_W-1:0] c_addr_one  = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  c_max       = CNT_W'(MAX_CYCLES);
    localparam logic [CNT_W-1:0]  c_cnt_one   = CNT_W'(1);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_wptr;
    logic              r_busy;
    logic [c_bc_w-1:0] r_byte_cnt;
    logic [DATA_W-1:0] r_word;
    logic              r_last;
    logic              r_wr_en;
    logic              r_ld_ready;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [7:0]        r_mem_wdata;
    logic              r_core_rst;
    logic              r_done;
    logic              r_timed_out;
    logic              r_ovf;
    logic [CNT_W-1:0]  r_cycle_count;
    logic [ADDR_W-1:0] r_pc_prev;
    logic              r_pc_valid;

    logic              w_oob;
    logic              w_halt;
    logic [CNT_W-1:0]  w_cnt_next;

    // Extra top bit keeps the range check from wrapping near the address limit.
    assign w_oob      = ({1'b0, r_wptr} + c_last_off) >= c_mem_bytes;
    assign w_halt     = r_pc_valid && (bus.core_pc == r_pc_prev);
    assign w_cnt_next = r_cycle_count + c_cnt_one;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= c_st_load;
            r_wptr        <= c_base;
            r_busy        <= 1'b0;
            r_byte_cnt    <= '0;
            r_word        <= '0;
            r_last        <= 1'b0;
            r_wr_en       <= 1'b0;
            r_ld_ready    <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_core_rst    <= 1'b1;
            r_done        <= 1'b0;
            r_timed_out   <= 1'b0;
            r_ovf         <= 1'b0;
            r_cycle_count <= '0;
            r_pc_prev     <= '0;
            r_pc_valid    <= 1'b0;
        end else begin
            case (r_state)
                c_st_load: begin
                    if (!r_busy) begin
                        if (bus.ld_valid && r_ld_ready) begin
                            r_busy      <= 1'b1;
                            r_byte_cnt  <= c_bc_one;
                            r_word      <= bus.ld_data << 8;
                            r_last      <= bus.ld_last;
                            r_wr_en     <= !w_oob;
                            r_mem_we    <= !w_oob;
                            r_mem_addr  <= r_wptr;
                            r_mem_wdata <= bus.ld_data[DATA_W-1 -: 8];
                            r_ld_ready  <= 1'b0;
                            if (w_oob) begin
                                r_ovf <= 1'b1;
                            end
                        end else begin
                            r_ld_ready <= 1'b1;
                        end
                    end else if (r_byte_cnt != c_bc_nb) begin
                        r_mem_we    <= r_wr_en;
                        r_mem_addr  <= r_mem_addr + c_addr_one;
                        r_mem_wdata <= r_word[DATA_W-1 -: 8];
                        r_word      <= r_word << 8;
                        r_byte_cnt  <= r_byte_cnt + c_bc_one;
                    end else begin
                        // Idle cycle after the last byte keeps the cadence at NB+1.
                        r_busy   <= 1'b0;
                        r_mem_we <= 1'b0;
                        r_wptr   <= r_wptr + c_nb_addr;
                        if (r_last) begin
                            r_state    <= c_st_arm;
                            r_ld_ready <= 1'b0;
                        end else begin
                            r_ld_ready <= 1'b1;
                        end
                    end
                end
                c_st_arm: begin
                    if (bus.start) begin
                        r_state    <= c_st_run;
                        r_core_rst <= 1'b0;
                    end
                end
                c_st_run: begin
                    r_cycle_count <= w_cnt_next;
                    r_pc_prev     <= bus.core_pc;
                    r_pc_valid    <= 1'b1;
                    // Halt takes priority when it coincides with the budget running out.
                    if (w_halt) begin
                        r_state     <= c_st_done;
                        r_done      <= 1'b1;
                        r_timed_out <= 1'b0;
                        r_core_rst  <= 1'b1;
                    end else if (w_cnt_next == c_max) begin
                        r_state     <= c_st_done;
                        r_done      <= 1'b1;
                        r_timed_out <= 1'b1;
                        r_core_rst  <= 1'b1;
                    end
                end
                c_st_done: begin
                    if (bus.clear) begin
                        r_state       <= c_st_load;
                        r_wptr        <= c_base;
                        r_cycle_count <= '0;
                        r_done        <= 1'b0;
                        r_timed_out   <= 1'b0;
                        r_pc_valid    <= 1'b0;
                        r_ld_ready    <= 1'b1;
                    end
                end
                default: r_state <= c_st_load;
            endcase
        end
    end

    assign bus.ld_ready    = r_ld_ready;
    assign bus.mem_we      = r_mem_we;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_wdata   = r_mem_wdata;
    assign bus.core_rst    = r_core_rst;
    assign bus.done        = r_done;
    assign bus.timed_out   = r_timed_out;
    assign bus.ovf         = r_ovf;
    assign bus.cycle_count = r_cycle_count;
endmodule
`default_nettype wire

// File: tb/tb_prog_loader_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_loader_ctrl
// Brief    : Directed and random stimulus checked against a queue-based model.
// Revision : 1.0
// ============================================================================
module tb_prog_loader_ctrl;
    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 32;
    localparam int MEM_BYTES  = 1024;
    localparam int BASE_ADDR  = 0;
    localparam int CNT_W      = 16;
    localparam int MAX_CYCLES = 100;
    localparam int NB         = DATA_W / 8;
    localparam int M_LOAD = 0, M_ARM = 1, M_RUN = 2, M_DONE = 3;
    localparam int PM_HALT = 0, PM_LOOP = 1, PM_RAND = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    prog_loader_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    prog_loader_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES),
        .BASE_ADDR(BASE_ADDR), .CNT_W(CNT_W), .MAX_CYCLES(MAX_CYCLES)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct packed { logic we; logic [31:0] addr; logic [7:0] data; } wr_t;

    wr_t         q[$];
    int          m_mode;
    int unsigned m_wptr;
    bit          m_pend_last, m_pc_valid;
    logic [ADDR_W-1:0] m_pc_prev;
    bit          e_ready, e_we, e_core_rst, e_done, e_to, e_ovf;
    int unsigned e_addr, e_cnt;
    logic [7:0]  e_wdata;

    int errors = 0, checks = 0, cyc = 0;
    logic [7:0] mem [MEM_BYTES];
    int wr_count, first_acc, last_acc, pc_mode, wr_snap;
    bit acc_flag, want_first, run_started;
    logic [31:0] first_wr_addr, w255;
    logic [ADDR_W-1:0] pc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Spec-level model: an accepted word becomes NB queued byte writes, one per cycle.
    task automatic model_update();
        bit popped, oob, halt;
        wr_t e;
        popped = 0;
        if (!reset) begin
            q.delete();
            m_mode = M_LOAD; m_wptr = BASE_ADDR; m_pend_last = 0; m_pc_valid = 0; m_pc_prev = '0;
            e_ready = 0; e_we = 0; e_addr = 0; e_wdata = 0; e_core_rst = 1;
            e_done = 0; e_to = 0; e_ovf = 0; e_cnt = 0;
        end else begin
            case (m_mode)
                M_LOAD: begin
                    if (e_ready && bus.ld_valid) begin
                        oob = (m_wptr + NB - 1) >= MEM_BYTES;
                        if (oob) e_ovf = 1;
                        for (int k = 0; k < NB; k++)
                            q.push_back('{we: !oob, addr: m_wptr + k,
                                          data: 8'(bus.ld_data >> (DATA_W - 8 - 8 * k))});
                        m_wptr += NB;
                        m_pend_last = bus.ld_last;
                        acc_flag = 1;
                        if (first_acc < 0) first_acc = cyc;
                        last_acc = cyc;
                    end
                    if (q.size() > 0) begin
                        e = q.pop_front();
                        e_we = e.we; e_addr = e.addr; e_wdata = e.data; popped = 1;
                    end else begin
                        e_we = 0;
                        if (m_pend_last) begin m_mode = M_ARM; m_pend_last = 0; end
                    end
                    e_ready = (m_mode == M_LOAD) && !popped;
                end
                M_ARM: if (bus.start) begin m_mode = M_RUN; e_core_rst = 0; end
                M_RUN: begin
                    e_cnt = (e_cnt + 1) % (1 << CNT_W);
                    halt = m_pc_valid && (bus.core_pc == m_pc_prev);
                    m_pc_prev = bus.core_pc; m_pc_valid = 1;
                    if (halt || e_cnt == MAX_CYCLES) begin
                        m_mode = M_DONE; e_done = 1; e_to = !halt; e_core_rst = 1;
                    end
                end
                default: if (bus.clear) begin
                    m_mode = M_LOAD; m_wptr = BASE_ADDR; e_cnt = 0;
                    e_done = 0; e_to = 0; m_pc_valid = 0; e_ready = 1;
                end
            endcase
        end
    endtask

    function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] p);
        case (pc_mode)
            PM_HALT: next_pc = (p == 32'h38) ? p : p + 4;
            PM_LOOP: next_pc = (p + 4) & 32'h1f;
            default: next_pc = ADDR_W'($urandom_range(0, 3) * 4);
        endcase
    endfunction

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        cyc++;
        chk("ld_ready", bus.ld_ready, e_ready);
        chk("mem_we", bus.mem_we, e_we);
        chk("mem_addr", bus.mem_addr, e_addr);
        chk("mem_wdata", bus.mem_wdata, e_wdata);
        chk("core_rst", bus.core_rst, e_core_rst);
        chk("done", bus.done, e_done);
        chk("timed_out", bus.timed_out, e_to);
        chk("ovf", bus.ovf, e_ovf);
        chk("cycle_count", bus.cycle_count, e_cnt);
        if (bus.mem_we) begin
            if (bus.mem_addr < MEM_BYTES) mem[bus.mem_addr[9:0]] = bus.mem_wdata;
            wr_count++;
            if (want_first) begin first_wr_addr = bus.mem_addr; want_first = 0; end
        end
        // Core stand-in: PC 0 while held, first RUN cycle at 0, then follows pc_mode.
        if (e_core_rst) begin pc = '0; run_started = 0; end
        else if (!run_started) run_started = 1;
        else pc = next_pc(pc);
        bus.core_pc = pc;
    endtask

    task automatic load_word(input logic [DATA_W-1:0] d, input bit last);
        bus.ld_valid = 1; bus.ld_data = d; bus.ld_last = last;
        acc_flag = 0;
        for (int i = 0; i < 4 * NB + 8 && !acc_flag; i++) step();
        chk("accept_wait", acc_flag, 1'b1);
    endtask

    task automatic wait_mode(input int m, input int bound);
        for (int i = 0; i < bound && m_mode != m; i++) step();
        chk("wait_mode", m_mode, m);
    endtask

    task automatic pulse(input bit is_start);
        if (is_start) bus.start = 1; else bus.clear = 1;
        step();
        bus.start = 0; bus.clear = 0;
    endtask

    logic [31:0] prog [14] = '{32'h00000000, 32'h06400a13, 32'h00000093, 32'h00100113,
                               32'h002081b3, 32'h00010093, 32'h00018113, 32'hfffa0a13,
                               32'hfe0a18e3, 32'h00302023, 32'h00000013, 32'h00000013,
                               32'h00000013, 32'hfe9ff56f};

    initial begin
        reset = 0; bus.ld_valid = 0; bus.ld_data = '0; bus.ld_last = 0;
        bus.start = 0; bus.clear = 0; bus.core_pc = '0; pc = '0;
        pc_mode = PM_HALT; wr_count = 0; first_acc = -1; last_acc = 0;
        want_first = 0; run_started = 0; first_wr_addr = '1;
        for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'hAA;

        // Reset values, release, start ignored in LOAD
        repeat (3) step();
        chk("rst_ld_ready", bus.ld_ready, 1'b0);
        chk("rst_core_rst", bus.core_rst, 1'b1);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        reset = 1; bus.start = 1;
        step();
        chk("ready_after_release", bus.ld_ready, 1'b1);
        bus.start = 0;
        step();
        chk("start_in_load_ignored", bus.core_rst, 1'b1);

        // 14-word program with ld_valid held high
        for (int i = 0; i < 14; i++) load_word(prog[i], i == 13);
        bus.ld_valid = 0; bus.ld_last = 0;
        wait_mode(M_ARM, NB + 4);
        chk("load_writes", wr_count, 56);
        chk("mem4", mem[4], 8'h06);
        chk("mem7", mem[7], 8'h13);
        chk("mem55", mem[55], 8'h6f);
        chk("load_cadence", last_acc - first_acc, 65);
        chk("arm_core_rst", bus.core_rst, 1'b1);
        chk("arm_ld_ready", bus.ld_ready, 1'b0);

        // Run to jump-to-self at 0x38; clear during RUN is ignored
        pc_mode = PM_HALT;
        pulse(1);
        repeat (2) step();
        pulse(0);
        chk("clear_in_run_ignored", bus.core_rst, 1'b0);
        wait_mode(M_DONE, 200);
        chk("halt_done", bus.done, 1'b1);
        chk("halt_timed_out", bus.timed_out, 1'b0);
        chk("halt_cycles", bus.cycle_count, 16);
        repeat (2) step();
        chk("halt_cnt_frozen", bus.cycle_count, 16);
        chk("mem60_63", {mem[60], mem[61], mem[62], mem[63]}, 32'hAAAAAAAA);
        pulse(0);
        chk("clear_cnt", bus.cycle_count, 0);
        chk("clear_done", bus.done, 1'b0);

        // Non-halting loop runs into the budget
        want_first = 1; first_wr_addr = '1;
        for (int i = 0; i < 4; i++) load_word($urandom, i == 3);
        bus.ld_valid = 0; bus.ld_last = 0;
        chk("base_after_clear", first_wr_addr, BASE_ADDR);
        wait_mode(M_ARM, NB + 4);
        pc_mode = PM_LOOP;
        pulse(1);
        wait_mode(M_DONE, 300);
        chk("timeout_cycles", bus.cycle_count, 100);
        chk("timeout_flag", bus.timed_out, 1'b1);
        pulse(0);

        // Reset during byte 2 of the third word
        load_word($urandom, 0);
        load_word($urandom, 0);
        load_word(32'hA1B2C3D4, 0);
        bus.ld_valid = 0;
        repeat (2) step();
        chk("byte2_data", bus.mem_wdata, 8'hC3);
        reset = 0; wr_snap = wr_count;
        step();
        chk("rst_mid_we", bus.mem_we, 1'b0);
        chk("rst_mid_addr", bus.mem_addr, 32'h0);
        repeat (2) step();
        chk("rst_mid_no_writes", wr_count, wr_snap);
        reset = 1;
        step();
        chk("rst_mid_ready", bus.ld_ready, 1'b1);
        want_first = 1; first_wr_addr = '1;
        load_word($urandom, 0);
        bus.ld_valid = 0;
        chk("rst_mid_base", first_wr_addr, BASE_ADDR);

        // 257 words into a 256-word memory
        reset = 0; repeat (2) step(); reset = 1; step();
        wr_count = 0; first_acc = -1; w255 = '0;
        for (int i = 0; i < 257; i++) begin
            logic [31:0] d;
            d = $urandom;
            if (i == 255) w255 = d;
            if (i == 256) chk("ovf_before", bus.ovf, 1'b0);
            load_word(d, i == 256);
        end
        bus.ld_valid = 0; bus.ld_last = 0;
        wait_mode(M_ARM, NB + 4);
        chk("ovf_set", bus.ovf, 1'b1);
        chk("ovf_writes", wr_count, 1024);
        chk("ovf_cadence", last_acc - first_acc, 1280);
        chk("mem1023", mem[1023], w255[7:0]);

        // Random soup
        pc_mode = PM_RAND;
        for (int i = 0; i < 3000; i++) begin
            reset        = ($urandom_range(0, 199) != 0);
            bus.ld_valid = ($urandom_range(0, 9) < 7);
            bus.ld_data  = $urandom;
            bus.ld_last  = ($urandom_range(0, 15) == 0);
            bus.start    = ($urandom_range(0, 7) == 0);
            bus.clear    = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
        $fatal(1);
    end
endmodule
`default_nettype wire
